// File: rtl/shift_rows_stream.sv
// Streaming ShiftRows / InvShiftRows for Rijndael states of NB = 4, 6 or 8 columns.
// The transformed state and its tag are buffered in a small registered FIFO.
module shift_rows_stream #(
  parameter int NB    = 4,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  localparam int W    = 32 * NB,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("shift_rows_stream: DEPTH must be 1..8");
  end

  logic [W-1:0] w_fwd;
  logic [W-1:0] w_inv;
  logic [W-1:0] w_xform;
  logic         w_push;
  logic         w_pop;

  // Pure byte permutation: byte (4c + r) sits at bits [W-1-8(4c+r) -: 8].
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int S     = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int DST   = W - 1 - 8 * (4 * c + r);
      localparam int SRC_F = W - 1 - 8 * (4 * ((c + S) % NB) + r);
      localparam int SRC_I = W - 1 - 8 * (4 * ((c + NB - S) % NB) + r);
      assign w_fwd[DST -: 8] = in_data[SRC_F -: 8];
      assign w_inv[DST -: 8] = in_data[SRC_I -: 8];
    end
  end

  assign w_xform = in_inv ? w_inv : w_fwd;

  logic [W-1:0]     r_mem [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Handshake: a beat transfers on any edge where valid && ready; in_ready is a
  // pure decode of the registered count, so a pop never frees a slot in the same cycle.
  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_data  = r_mem[r_rptr];
  assign out_tag   = r_tag[r_rptr];
  assign count     = r_count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
        r_tag[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_xform;
        r_tag[r_wptr] <= in_tag;
        r_wptr        <= next_ptr(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= next_ptr(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Bench for shift_rows_stream: an NB=4/DEPTH=2 and an NB=8/DEPTH=3 instance, directed
// vectors followed by random traffic scored against a row-rotation reference model.
module tb_shift_rows_stream;
  localparam int TW = 4;
  localparam int D4 = 2;
  localparam int D8 = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           v4 = 1'b0, inv4 = 1'b0, or4 = 1'b1;
  logic           ir4, ov4;
  logic [127:0]   d4 = '0, od4;
  logic [TW-1:0]  t4 = '0, ot4;
  logic [1:0]     c4;

  logic           v8 = 1'b0, inv8 = 1'b0, or8 = 1'b1;
  logic           ir8, ov8;
  logic [255:0]   d8 = '0, od8;
  logic [TW-1:0]  t8 = '0, ot8;
  logic [1:0]     c8;

  shift_rows_stream #(.NB(4), .DEPTH(D4), .TAG_W(TW)) u_dut4 (
    .clk(clk), .reset(rst), .in_valid(v4), .in_ready(ir4), .in_data(d4),
    .in_inv(inv4), .in_tag(t4), .out_valid(ov4), .out_ready(or4),
    .out_data(od4), .out_tag(ot4), .count(c4)
  );

  shift_rows_stream #(.NB(8), .DEPTH(D8), .TAG_W(TW)) u_dut8 (
    .clk(clk), .reset(rst), .in_valid(v8), .in_ready(ir8), .in_data(d8),
    .in_inv(inv8), .in_tag(t8), .out_valid(ov8), .out_ready(or8),
    .out_data(od8), .out_tag(ot8), .count(c8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [259:0] obs, input logic [259:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: state right-aligned in the low nb*32 bits; each row is pulled out as a
  // list of bytes and rotated left (forward) or right (inverse) by its shift amount.
  function automatic logic [255:0] ref_shift(input logic [255:0] st, input int nb, input bit inv);
    logic [7:0]   row[$];
    logic [255:0] res = '0;
    int           w = nb * 32;
    int           s;
    for (int r = 0; r < 4; r++) begin
      row.delete();
      for (int c = 0; c < nb; c++) row.push_back(st[w-1-8*(4*c+r) -: 8]);
      s = (nb == 8 && r >= 2) ? r + 1 : r;
      repeat (s) begin
        if (inv) row.push_front(row.pop_back());
        else     row.push_back(row.pop_front());
      end
      for (int c = 0; c < nb; c++) res[w-1-8*(4*c+r) -: 8] = row[c];
    end
    return res;
  endfunction

  // scoreboards: expected {tag, data} in FIFO order
  logic [TW+127:0] exp_q4[$];
  logic [TW+255:0] exp_q8[$];

  always @(negedge clk) begin : mon4
    int           sz;
    logic [255:0] m;
    if (rst) exp_q4.delete();
    else begin
      sz = exp_q4.size();
      check("count4", 260'(c4), 260'(sz));
      check("in_ready4", 260'(ir4), 260'(sz < D4));
      check("out_valid4", 260'(ov4), 260'(sz != 0));
      if (sz != 0) begin
        check("data4", 260'(od4), 260'(exp_q4[0][127:0]));
        check("tag4", 260'(ot4), 260'(exp_q4[0][TW+127:128]));
        if (or4) void'(exp_q4.pop_front());
      end
      if (v4 && sz < D4) begin
        m = ref_shift({128'b0, d4}, 4, inv4);
        exp_q4.push_back({t4, m[127:0]});
      end
    end
  end

  always @(negedge clk) begin : mon8
    int sz;
    if (rst) exp_q8.delete();
    else begin
      sz = exp_q8.size();
      check("count8", 260'(c8), 260'(sz));
      check("in_ready8", 260'(ir8), 260'(sz < D8));
      check("out_valid8", 260'(ov8), 260'(sz != 0));
      if (sz != 0) begin
        check("data8", 260'(od8), 260'(exp_q8[0][255:0]));
        check("tag8", 260'(ot8), 260'(exp_q8[0][TW+255:256]));
        if (or8) void'(exp_q8.pop_front());
      end
      if (v8 && sz < D8) exp_q8.push_back({t8, ref_shift(d8, 8, inv8)});
    end
  end

  localparam logic [127:0] VEC_A = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] RES_A = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] VEC_B = 128'h49ded28945db96f17f39871a7702533b;
  localparam logic [127:0] RES_B = 128'h49db873b453953897f02d2f177de961a;
  localparam logic [255:0] RES8  =
    256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

  logic [255:0] seq8;
  logic [127:0] hold4;

  initial begin
    for (int k = 0; k < 32; k++) seq8[255-8*k -: 8] = 8'(k);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_count", 260'(c4), 260'(0));
    check("rst_out_valid", 260'(ov4), 260'(0));
    check("rst_in_ready", 260'(ir4), 260'(1));
    check("rst_out_data", 260'(od4), 260'(0));
    check("rst_out_tag", 260'(ot4), 260'(0));
    check("rst_out_data8", 260'(od8), 260'(0));

    // forward NB=4
    @(posedge clk); #1 v4 = 1'b1; d4 = VEC_A; inv4 = 1'b0; t4 = 4'd5; or4 = 1'b1;
    @(posedge clk); #1 v4 = 1'b0;
    @(negedge clk);
    check("fwd_valid", 260'(ov4), 260'(1));
    check("fwd_data", 260'(od4), 260'(RES_A));
    check("fwd_tag", 260'(ot4), 260'(5));

    // inverse then forward, back to back
    @(posedge clk); #1 v4 = 1'b1; d4 = RES_A; inv4 = 1'b1; t4 = 4'd7;
    @(posedge clk); #1 d4 = VEC_B; inv4 = 1'b0; t4 = 4'd8;
    @(negedge clk);
    check("inv_data", 260'(od4), 260'(VEC_A));
    check("inv_tag", 260'(ot4), 260'(7));
    @(posedge clk); #1 v4 = 1'b0;
    @(negedge clk);
    check("fwd2_data", 260'(od4), 260'(RES_B));
    check("fwd2_tag", 260'(ot4), 260'(8));

    // NB=8 forward, then inverse of the result
    @(posedge clk); #1 v8 = 1'b1; d8 = seq8; inv8 = 1'b0; t8 = 4'd3; or8 = 1'b1;
    @(posedge clk); #1 d8 = RES8; inv8 = 1'b1; t8 = 4'd4;
    @(negedge clk);
    check("nb8_fwd", 260'(od8), 260'(RES8));
    @(posedge clk); #1 v8 = 1'b0;
    @(negedge clk);
    check("nb8_inv", 260'(od8), 260'(seq8));

    // backpressure: three offers into a two-entry FIFO
    @(posedge clk); #1 or4 = 1'b0; v4 = 1'b1; t4 = 4'd1; inv4 = 1'($urandom);
    d4 = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1 t4 = 4'd2; d4 = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1 t4 = 4'd3; d4 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    check("full_in_ready", 260'(ir4), 260'(0));
    check("full_count", 260'(c4), 260'(2));
    check("full_head_tag", 260'(ot4), 260'(1));
    hold4 = od4;
    @(posedge clk); #1;
    @(negedge clk);
    check("held_count", 260'(c4), 260'(2));
    check("stall_data", 260'(od4), 260'(hold4));
    @(posedge clk); #1 or4 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("full_pop_count", 260'(c4), 260'(1));
    check("full_pop_tag", 260'(ot4), 260'(2));
    @(posedge clk); #1 v4 = 1'b0;
    @(negedge clk);
    check("push_pop_count", 260'(c4), 260'(1));
    check("push_pop_tag", 260'(ot4), 260'(3));

    // reset mid-stream with two entries buffered and a push offered
    @(posedge clk); #1 or4 = 1'b0; v4 = 1'b1; t4 = 4'd9;
    @(posedge clk); #1 t4 = 4'd10;
    @(posedge clk); #1 rst = 1'b1; t4 = 4'd11;
    @(posedge clk); #1 rst = 1'b0; v4 = 1'b0; or4 = 1'b1;
    @(negedge clk);
    check("mid_rst_count", 260'(c4), 260'(0));
    check("mid_rst_valid", 260'(ov4), 260'(0));
    check("mid_rst_ready", 260'(ir4), 260'(1));
    check("mid_rst_data", 260'(od4), 260'(0));
    repeat (4) @(negedge clk);
    check("no_stale", 260'(ov4), 260'(0));

    // random traffic with occasional resets
    repeat (600) begin
      @(posedge clk); #1;
      rst  = ($urandom_range(0, 99) == 0);
      v4   = 1'($urandom); inv4 = 1'($urandom); t4 = 4'($urandom);
      or4  = ($urandom_range(0, 3) != 0);
      d4   = {$urandom, $urandom, $urandom, $urandom};
      v8   = 1'($urandom); inv8 = 1'($urandom); t8 = 4'($urandom);
      or8  = ($urandom_range(0, 2) != 0);
      d8   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk); #1 rst = 1'b0; v4 = 1'b0; v8 = 1'b0; or4 = 1'b1; or8 = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("drain4", 260'(exp_q4.size()), 260'(0));
    check("drain8", 260'(exp_q8.size()), 260'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_rows_stream.md
Name: shift_rows_stream

Overview:
- Streaming, parametrised ShiftRows / InvShiftRows unit for the AES/Rijndael datapath.
- Generalises the combinational 128-bit ShiftRows to Rijndael block widths Nb = 4, 6 or 8 columns.
- Direction is selected per transaction (forward or inverse).
- Uses a valid/ready handshake and a registered result FIFO, so it can sit between pipelined SubBytes and MixColumns stages of the round pipeline.

Parameters:
- NB, 4, number of state columns (legal: 4, 6, 8); state width W = 32*NB.
- DEPTH, 2, result FIFO entries (legal: 1..8).
- TAG_W, 4, width of the sideband tag carried with each transaction.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  unit can accept an input this cycle.
- in_data  input  W  state, column-major, byte 0 = bits [W-1:W-8].
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows.
- in_tag  input  TAG_W  sideband tag, passed through unchanged.
- out_valid  output  1  result available at FIFO head.
- out_ready  input  1  downstream accepts result.
- out_data  output  W  transformed state.
- out_tag  output  TAG_W  tag of the head entry.
- count  output  clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Byte mapping: state[r][c] = byte (4c + r), where r = 0..3 and c = 0..NB-1.
- Row shifts s(r):
  - NB = 4 or 6: 0, 1, 2, 3.
  - NB = 8: 0, 1, 3, 4.
- Forward: out[r][c] = in[r][(c + s(r)) mod NB].
- Inverse: out[r][c] = in[r][(c - s(r)) mod NB].
- The transform is combinational on in_data. The result, not the raw input, is written to the FIFO.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH). It is a registered-count decode with no combinational path from out_ready.
  - When full, a simultaneous pop does not enable a push in that cycle.
- out_valid = (count != 0). out_data and out_tag are driven from the head entry.
- Output values are held stable while out_valid && !out_ready.
- Latency: an input accepted at edge k with the FIFO empty appears with out_valid = 1 after edge k.
- Throughput: one transaction per cycle while not full and out_ready = 1.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, ordering preserved (strict FIFO).
- Read and write pointers wrap modulo DEPTH. For DEPTH = 1, the pointers are constant.
- in_inv and in_tag are sampled only on a push. Values presented on non-accepted cycles are ignored.
- Reset (synchronous, any cycle including mid-stream):
  - count = 0, pointers = 0, out_valid = 0, in_ready = 1 in the cycle after reset is sampled.
  - out_data = 0, out_tag = 0.
  - All buffered results are discarded. A push coinciding with reset is dropped.
- Illegal NB values fail elaboration. There is no runtime error path.

Test Plan:
- NB=4, forward, out_ready=1: push 128'hd42711aee0bf98f1b8b45de51e415230 -> out_data 128'hd4bf5d30e0b452aeb84111f11e2798e5 one cycle later.
- NB=4, inverse: push 128'hd4bf5d30e0b452aeb84111f11e2798e5 with in_inv=1, then forward 128'h49ded28945db96f17f39871a7702533b -> outputs, in order:
  - 128'hd42711aee0bf98f1b8b45de51e415230, then
  - 128'h49db873b453953897f02d2f177de961a.
  - Each output carries the tag it was pushed with.
- NB=8, forward: push bytes 00..1f ascending -> out_data 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f. Inverse of that output returns the original input.
- DEPTH=2 backpressure: out_ready=0, offer 3 pushes with tags 1, 2, 3.
  - After 2 accepted: in_ready=0, count=2, third input held.
  - Raise out_ready: head tag 1, then 2, then 3, with out_data stable while stalled.
- Full plus pop: count=2, in_valid=1, out_ready=1 -> push refused that cycle and count=1. Next cycle push accepted with simultaneous pop, count stays 1.
- Reset mid-stream with count=2 and in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, out_data=0. No stale results emerge afterwards.
